// File: rtl/fc_layer_seq.sv
// Sequencer for one fully-connected layer: serial activation load, settle wait, result drain.
// Optional output saturation is enabled by defining FC_SEQ_SAT_EN.
module fc_layer_seq #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int NOUT   = 84,
  parameter int ACC_W  = WIDTH*2 + $clog2(IN),
  parameter int SETTLE = 4,
`ifdef FC_SEQ_SAT_EN
  parameter int SHIFT  = 7,
  localparam int OUT_W = WIDTH
`else
  localparam int OUT_W = ACC_W
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic [IN*WIDTH-1:0]     x_vec,
  input  logic [NOUT*ACC_W-1:0]   z_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [$clog2(NOUT)-1:0] out_idx,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              state_dbg
);

  localparam int IW = $clog2(IN);
  localparam int OW = $clog2(NOUT);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [IW-1:0] IN_LAST  = IW'(IN - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(NOUT - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          in_cnt;
  logic [SW-1:0]          set_cnt;
  logic [OW-1:0]          out_cnt;
  logic [IN*WIDTH-1:0]    x_q;
  logic [NOUT*ACC_W-1:0]  res_q;
  logic                   in_fire, out_fire;
  logic [ACC_W-1:0]       res_sel;

  // Handshake rule for both ports: a word moves on a rising edge where valid
  // and ready are both high; ready is a function of state only, never of valid.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    in_fire   = 1'b0;
    out_fire  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        if (in_valid && in_cnt == IN_LAST) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (set_cnt == SET_LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_fire  = out_ready;
        if (out_ready && out_cnt == OUT_LAST) begin
          done    = 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      in_cnt  <= '0;
      set_cnt <= '0;
      out_cnt <= '0;
      x_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        x_q[in_cnt*WIDTH +: WIDTH] <= in_data;
        in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + 1'b1;
      end
      // The neuron datapaths are a multicycle path: z_vec is only trusted
      // after x_vec has been frozen for SETTLE cycles.
      if (state_q == ST_SETTLE) begin
        set_cnt <= set_cnt + 1'b1;
        if (set_cnt == SET_LAST) res_q <= z_vec;
      end else begin
        set_cnt <= '0;
      end
      if (out_fire) out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + 1'b1;
    end
  end

  assign x_vec     = x_q;
  assign out_idx   = out_cnt;
  assign res_sel   = res_q[out_cnt*ACC_W +: ACC_W];
  assign state_dbg = state_q;

`ifdef FC_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((1 << (WIDTH-1)) - 1);
  localparam logic [OUT_W-1:0]        SAT_MAX_O = OUT_W'((1 << (WIDTH-1)) - 1);
  logic signed [ACC_W-1:0] shifted;
  assign shifted  = $signed(res_sel) >>> SHIFT;
  assign out_data = (shifted > SAT_MAX) ? SAT_MAX_O : shifted[OUT_W-1:0];
`else
  assign out_data = res_sel;
`endif

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq: neuron stub on z_vec, queue scoreboard,
// table-driven saturation vectors and hand-written reset/settle/backpressure sequences.
module tb_fc_layer_seq;

  localparam int WIDTH  = 8;
  localparam int IN     = 128;
  localparam int NOUT   = 84;
  localparam int ACC_W  = WIDTH*2 + $clog2(IN);
  localparam int SETTLE = 4;
  localparam int SHIFT  = 7;
  localparam int IDX_W  = $clog2(NOUT);
`ifdef FC_SEQ_SAT_EN
  localparam int OUT_W  = WIDTH;
`else
  localparam int OUT_W  = ACC_W;
`endif
  localparam int NT     = 8;

  logic                   clk, rst;
  logic                   in_valid, in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [IN*WIDTH-1:0]    x_vec;
  logic [NOUT*ACC_W-1:0]  z_vec;
  logic                   out_valid, out_ready;
  logic [OUT_W-1:0]       out_data;
  logic [IDX_W-1:0]       out_idx;
  logic                   busy, done;
  logic [1:0]             state_dbg;

  fc_layer_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_vec(x_vec), .z_vec(z_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  typedef struct {
    longint z;
    longint raw;
    longint sat;
  } tab_t;

  tab_t                   tab[NT];
  int                     z_mode;
  longint                 z_tab[NOUT];
  int                     cur_x[IN];
  logic [IDX_W+OUT_W-1:0] exp_q[$];
  logic [IDX_W+OUT_W-1:0] e;
  int                     n_cmp, n_bad;
  bit                     mon_en;
  int                     rdy_mode;
  int                     rdy_ph;
  int                     lat;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- neuron datapath stub and reference ----------------
  function automatic int wt(int n, int i);
    return ((n*7 + i*3) % 5) - 2;
  endfunction

  function automatic longint relu(longint s);
    return (s < 0) ? 0 : s;
  endfunction

  function automatic longint stub_z(logic [IN*WIDTH-1:0] xv, int n);
    longint s = 0;
    for (int i = 0; i < IN; i++) s += longint'($signed(xv[i*WIDTH +: WIDTH])) * wt(n, i);
    return relu(s);
  endfunction

  function automatic longint ref_z(int n);
    longint s = 0;
    for (int i = 0; i < IN; i++) s += longint'(cur_x[i]) * wt(n, i);
    return relu(s);
  endfunction

  function automatic logic [OUT_W-1:0] model_out(longint z);
`ifdef FC_SEQ_SAT_EN
    longint s = z / (longint'(1) << SHIFT);
    if (s > 127) s = 127;
    return s[OUT_W-1:0];
`else
    return z[OUT_W-1:0];
`endif
  endfunction

  always_comb begin
    longint zs;
    zs    = 0;
    z_vec = '0;
    for (int n = 0; n < NOUT; n++) begin
      if (z_mode == 1) zs = z_tab[n];
      else             zs = stub_z(x_vec, n);
      z_vec[n*ACC_W +: ACC_W] = zs[ACC_W-1:0];
    end
  end

  // ---------------- output ready driver ----------------
  initial begin
    out_ready = 1'b1;
    rdy_ph    = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       begin out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3); rdy_ph++; end
        2:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (out_valid) begin
        chk("busy_drain", busy, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_idx, -1);
        end else begin
          e = exp_q[0];
          chk("out_idx", out_idx, longint'(e[IDX_W+OUT_W-1:OUT_W]));
          chk("out_data", out_data, longint'(e[OUT_W-1:0]));
          chk("done", done, (out_ready && e[IDX_W+OUT_W-1:OUT_W] == IDX_W'(NOUT-1)) ? 1 : 0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("done_idle", done, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_x(input int kind);
    for (int i = 0; i < IN; i++)
      cur_x[i] = (kind == 0) ? 1 : int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic send_vector(input int gap_mode, input bit chk_pre);
    bit hs;
    int tmo;
    for (int i = 0; i < IN; i++) begin
      if ((gap_mode == 1 && i > 0 && i % 10 == 0) ||
          (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        repeat (gap_mode == 1 ? 3 : 1) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = WIDTH'(cur_x[i]);
      hs  = 1'b0;
      tmo = 0;
      while (!hs && tmo < 1000) begin
        @(negedge clk);
        hs = in_ready;
        if (chk_pre && i == IN-1 && tmo == 0) begin
          chk("busy_before_last", busy, 0);
          chk("ready_before_last", in_ready, 1);
        end
        @(posedge clk); #1;
        tmo++;
      end
      if (!hs) begin
        chk("in_hs_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic push_neuron();
    for (int n = 0; n < NOUT; n++) exp_q.push_back({IDX_W'(n), model_out(ref_z(n))});
  endtask

  task automatic push_tab();
    for (int n = 0; n < NOUT; n++) exp_q.push_back({IDX_W'(n), model_out(z_tab[n])});
  endtask

  task automatic wait_drain();
    int tmo = 0;
    while (exp_q.size() > 0 && tmo < 3000) begin
      @(posedge clk);
      tmo++;
    end
    #1;
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_xvec(input string nm);
    logic [IN*WIDTH-1:0] ev;
    for (int i = 0; i < IN; i++) ev[i*WIDTH +: WIDTH] = WIDTH'(cur_x[i]);
    n_cmp++;
    if (x_vec !== ev) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, x_vec, ev);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int tmo;
    tab[0] = '{200000, 200000, 127};
    tab[1] = '{640,    640,    5};
    tab[2] = '{0,      0,      0};
    tab[3] = '{16256,  16256,  127};
    tab[4] = '{16383,  16383,  127};
    tab[5] = '{16255,  16255,  126};
    tab[6] = '{127,    127,    0};
    tab[7] = '{128,    128,    1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    z_mode = 0; mon_en = 1'b0; rdy_mode = 0;
    n_cmp = 0; n_bad = 0;
    for (int n = 0; n < NOUT; n++) z_tab[n] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_x_vec_zero", (x_vec == '0) ? 1 : 0, 1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // All-ones input, z[n]=n+1, ready high: ordering, done and latency
    z_mode = 1;
    for (int n = 0; n < NOUT; n++) z_tab[n] = n + 1;
    fill_x(0);
    push_tab();
    lat = 0;
    fork
      send_vector(0, 1'b0);
      begin
        while (lat < 1000) begin
          @(negedge clk);
          if (out_valid) break;
          lat++;
        end
      end
    join
    chk("latency", lat, IN + SETTLE);
    wait_drain();

    // Backpressure 1,0,0,1 through drain
    z_mode   = 0;
    rdy_mode = 1;
    fill_x(1);
    send_vector(0, 1'b0);
    push_neuron();
    wait_drain();
    rdy_mode = 0;

    // Input gaps: settle begins only after the last handshake
    fill_x(1);
    send_vector(1, 1'b1);
    @(negedge clk);
    chk("gap_busy_after_last", busy, 1);
    chk("gap_ready_after_last", in_ready, 0);
    check_xvec("gap_x_vec");
    @(posedge clk); #1;
    push_neuron();
    wait_drain();

    // Settle sample point: z differs before, at and after the sample edge
    z_mode = 1;
    for (int n = 0; n < NOUT; n++) z_tab[n] = $urandom_range(0, 300000);
    fill_x(1);
    send_vector(0, 1'b0);
    repeat (SETTLE-1) @(posedge clk);
    #1;
    for (int n = 0; n < NOUT; n++) z_tab[n] = $urandom_range(0, 300000);
    @(posedge clk); #1;
    push_tab();
    for (int n = 0; n < NOUT; n++) z_tab[n] = z_tab[n] + 1 + $urandom_range(0, 1000);
    wait_drain();

    // Table vectors: saturation / pass-through of out_data
    mon_en = 1'b0;
    for (int n = 0; n < NOUT; n++) z_tab[n] = 0;
    for (int k = 0; k < NT; k++) z_tab[k] = tab[k].z;
    fill_x(1);
    send_vector(0, 1'b0);
    for (int k = 0; k < NOUT; k++) begin
      tmo = 0;
      @(negedge clk);
      while (!out_valid && tmo < 50) begin
        @(negedge clk);
        tmo++;
      end
      if (!out_valid) begin
        chk("tab_valid", 0, 1);
        break;
      end
      if (k < NT) begin
        chk("tab_idx", out_idx, k);
`ifdef FC_SEQ_SAT_EN
        chk("tab_data", out_data, tab[k].sat);
`else
        chk("tab_data", out_data, tab[k].raw);
`endif
      end
      if (k == NOUT-1) chk("tab_done_last", done, 1);
      @(posedge clk);
    end
    #1;

    // Reset in the middle of drain, then a fresh load
    z_mode = 0;
    fill_x(1);
    send_vector(0, 1'b0);
    tmo = 0;
    @(negedge clk);
    while (!(out_valid && out_idx == IDX_W'(40)) && tmo < 300) begin
      @(negedge clk);
      tmo++;
    end
    chk("rst_reach_idx40", out_idx, 40);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_idx", out_idx, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    fill_x(1);
    send_vector(0, 1'b0);
    @(negedge clk);
    check_xvec("reload_x_vec");
    @(posedge clk); #1;
    push_neuron();
    wait_drain();

    // Random back-to-back vectors with random gaps and random ready
    rdy_mode = 2;
    for (int v = 0; v < 4; v++) begin
      fill_x(1);
      send_vector(2, 1'b0);
      push_neuron();
    end
    wait_drain();
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
